// File: rtl/key_request_latch_pkg.sv
// Shared definitions for the key request latch: FSM encoding and
// simulation-friendly constants used by the block and its bench.
package key_request_latch_pkg;

    // Two-state handshake FSM; the state bit doubles as the valid output.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Number of push-button lines handled by the block.
    localparam int NUM_KEYS = 4;

    // Short debounce window for simulation runs.
    localparam int DB_CNT_MAX_SIM = 4;

endpackage

// File: rtl/key_request_latch_debounce_bit.sv
// One key lane: 2-flop synchronizer, debounce counter and stable level.
// o_rise is asserted combinationally during the cycle whose closing edge
// moves the stable level from 0 to 1, so the parent can latch the press
// on the very edge that the level changes.
module debounce_bit
    import key_request_latch_pkg::*;
#(
    parameter int DB_CNT_MAX = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic             w_change;
    logic             w_expire;

    assign w_change = (r_sync != r_stable);
    assign w_expire = (r_cnt == CNT_LAST);

    // Bring the raw asynchronous key line into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_key;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after it has persisted for the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_change) begin
            r_cnt <= '0;
        end else if (w_expire) begin
            r_stable <= r_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_change && w_expire && r_sync;

endmodule

// File: rtl/key_request_latch.sv
// Front end for a 4-input priority encoder: debounces four buttons,
// accumulates press events and presents them with a valid/ack handshake.
//
// Handshake: valid is high while data_out holds an unconsumed, non-zero
// press vector; data_out is frozen while valid is high. The consumer
// raises ack for a cycle while valid is high to take the vector; valid
// falls after that edge and stays low at least one full cycle before
// the next vector is offered. ack is ignored while valid is low.
module key_request_latch
    import key_request_latch_pkg::*;
#(
    parameter int DB_CNT_MAX = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       ack,
    output logic [3:0] data_out,
    output logic       valid,
    output logic [3:0] key_level
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pending;
    logic [3:0] w_pending_nxt;
    logic [3:0] r_data;
    logic [3:0] w_data_nxt;
    logic [3:0] w_rise;
    logic [3:0] w_level;

    // One debouncer per key line.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        debounce_bit #(
            .DB_CNT_MAX (DB_CNT_MAX),
            .CNT_W      (CNT_W)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_key   (key_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Next-state logic: capture pending into data_out from IDLE, hold until ack.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending | w_rise;
        w_data_nxt    = r_data;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != 4'b0000) begin
                    w_data_nxt    = r_pending;
                    // Captured bits are handed over; presses landing this edge stay queued.
                    w_pending_nxt = w_rise;
                    w_state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pending accumulator and output data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 4'b0000;
            r_data    <= 4'b0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign valid     = (r_state == ST_HOLD);
    assign data_out  = r_data;
    assign key_level = w_level;

endmodule

// File: tb/tb_key_request_latch.sv
// Bench for key_request_latch with a short debounce window: table of
// press/glitch vectors plus hand-written reset and HOLD corner cases.
// Expected event vectors go into exp_q when keys are driven; a monitor
// pops and compares them when valid rises.
module tb_key_request_latch;
    import key_request_latch_pkg::*;

    localparam int DB = DB_CNT_MAX_SIM;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] key_in = 4'b0000;
    logic [3:0] data_out;
    logic       valid;
    logic [3:0] key_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] exp_data;
        logic       exp_evt;
    } vec_t;

    vec_t vecs[6];

    key_request_latch #(
        .DB_CNT_MAX (DB),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .ack       (ack),
        .data_out  (data_out),
        .valid     (valid),
        .key_level (key_level)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each new event, and data_out stability in HOLD.
    logic       r_prev_valid = 1'b0;
    logic [3:0] r_prev_data  = 4'b0000;
    always @(negedge clk) begin
        if (valid === 1'b1 && r_prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got data_out=%b expected no event", data_out);
            end else begin
                check4("event_data", data_out, exp_q.pop_front());
            end
        end else if (valid === 1'b1 && r_prev_valid === 1'b1) begin
            check4("hold_stable", data_out, r_prev_data);
        end
        r_prev_valid = valid;
        r_prev_data  = data_out;
    end

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check1("valid_after_ack", valid, 1'b0);
    endtask

    task automatic release_and_settle();
        key_in = 4'b0000;
        repeat (DB + 6) @(negedge clk);
        check4("level_released", key_level, 4'b0000);
        check1("no_release_event", valid, 1'b0);
    endtask

    bit ok;

    initial begin
        // Vector table: keys, glitch hold cycles, expected event data, event expected.
        vecs[0] = '{keys: 4'b0100, hold: 0, exp_data: 4'b0100, exp_evt: 1'b1};
        vecs[1] = '{keys: 4'b1010, hold: 0, exp_data: 4'b1010, exp_evt: 1'b1};
        vecs[2] = '{keys: 4'b0001, hold: 3, exp_data: 4'b0000, exp_evt: 1'b0};
        vecs[3] = '{keys: 4'b1111, hold: 0, exp_data: 4'b1111, exp_evt: 1'b1};
        vecs[4] = '{keys: 4'b0011, hold: 2, exp_data: 4'b0000, exp_evt: 1'b0};
        vecs[5] = '{keys: 4'b1000, hold: 0, exp_data: 4'b1000, exp_evt: 1'b1};

        // Reset with all keys held.
        key_in = 4'b1111;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("rst_valid", valid, 1'b0);
        check4("rst_data", data_out, 4'b0000);
        check4("rst_level", key_level, 4'b0000);
        exp_q.push_back(4'b1111);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check4("rst_level_at_6", key_level, 4'b1111);
        check1("rst_valid_low_at_6", valid, 1'b0);
        @(negedge clk);
        check1("rst_valid_at_7", valid, 1'b1);
        check4("rst_data_at_7", data_out, 4'b1111);
        do_ack();
        repeat (3) @(negedge clk);
        check1("rst_valid_stays_low", valid, 1'b0);
        release_and_settle();

        // Table-driven presses and glitches.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            key_in = vecs[i].keys;
            if (vecs[i].exp_evt) begin
                exp_q.push_back(vecs[i].exp_data);
                repeat (6) @(negedge clk);
                check4("level_at_6", key_level, vecs[i].keys);
                check1("valid_low_at_6", valid, 1'b0);
                @(negedge clk);
                check1("valid_at_7", valid, 1'b1);
                do_ack();
                repeat (3) @(negedge clk);
                check1("valid_stays_low", valid, 1'b0);
                release_and_settle();
            end else begin
                repeat (vecs[i].hold) @(negedge clk);
                key_in = 4'b0000;
                for (int c = 0; c < DB + 6; c++) begin
                    @(negedge clk);
                    check1("glitch_valid", valid, 1'b0);
                    check4("glitch_level", key_level, 4'b0000);
                end
            end
        end

        // Press of key0 while a key2 event is held.
        @(negedge clk);
        key_in = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_valid(20, ok);
        check1("hold_first_event", ok, 1'b1);
        key_in = 4'b0101;
        exp_q.push_back(4'b0001);
        for (int c = 0; c < DB + 6; c++) begin
            @(negedge clk);
            check1("hold_valid", valid, 1'b1);
            check4("hold_data", data_out, 4'b0100);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check1("hold_gap_low", valid, 1'b0);
        wait_valid(4, ok);
        check1("hold_second_event", ok, 1'b1);
        check4("hold_second_data", data_out, 4'b0001);
        do_ack();
        release_and_settle();

        // Reset while HOLD with another press pending.
        @(negedge clk);
        key_in = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_valid(20, ok);
        check1("mid_first_event", ok, 1'b1);
        key_in = 4'b0011;
        repeat (DB + 6) @(negedge clk);
        check1("mid_still_hold", valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("mid_async_valid", valid, 1'b0);
        check4("mid_async_data", data_out, 4'b0000);
        check4("mid_async_level", key_level, 4'b0000);
        repeat (2) @(negedge clk);
        exp_q.push_back(4'b0011);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check4("mid_level_at_6", key_level, 4'b0011);
        check1("mid_no_stale", valid, 1'b0);
        @(negedge clk);
        check1("mid_valid_at_7", valid, 1'b1);
        do_ack();
        release_and_settle();

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL exp_q_drained: got %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
